// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
// State encodings, BCD limits and counter sizing.
package seg_scan_ctrl_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: counts up to a selectable terminal value,
// flags it, and wraps to zero on the next edge.
module seg_scan_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] lim_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o  = (cnt_q == lim_i);
  assign cnt_d = tc_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with blanking gaps
// and frame-synchronous double-buffered snapshots.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  input  logic                      lz_suppress,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [3:0]                digit_code,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = BCD_W * NUM_DIGITS;
  localparam int CW = cnt_width(REFRESH_DIV, BLANK_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         shadow_q, shadow_d;
  logic [SW-1:0]         pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [3:0]            code_q, code_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic          tc;
  logic          boundary;
  logic [CW-1:0] lim;
  logic [3:0]    cur;
  logic          zacc;
  logic          sup;

  assign lim = (state_q == ST_SHOW) ? CW'(REFRESH_DIV - 1)
                                    : CW'(BLANK_CYCLES - 1);

  seg_scan_timer #(
    .CW (CW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .lim_i (lim),
    .tc_o  (tc)
  );

  assign boundary = (state_q == ST_SHOW) && tc && (idx_q == LAST);

  always_comb begin
    state_d  = tc ? ~state_q : state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if ((state_q == ST_SHOW) && tc) begin
      idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    end
    // A load landing on the boundary itself wins over any pending snapshot
    if (boundary) begin
      if (load) begin
        shadow_d = digits_in;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        shadow_d = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (load) begin
      pend_d   = digits_in;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    cur  = shadow_d[BCD_W*idx_d +: BCD_W];
    zacc = 1'b1;
    sup  = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zacc = zacc & (shadow_d[BCD_W*i +: BCD_W] == 4'd0);
      if (idx_d == IW'(i)) sup = zacc & lz_suppress;
    end
    code_d = cur;
    en_d   = '0;
    dp_d   = 1'b0;
    fd_d   = boundary;
    if (state_d == ST_SHOW) begin
      if (!sup && (cur <= BCD_MAX)) begin
        en_d = NUM_DIGITS'(1) << idx_d;
      end
      dp_d = dp_mask[idx_d] & ~sup;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BLANK;
      idx_q    <= '0;
      shadow_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      code_q   <= '0;
      en_q     <= '0;
      dp_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      code_q   <= code_d;
      en_q     <= en_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign digit_code = code_q;
  assign digit_en   = en_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
